alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/alu_muldiv_seq.sv | 170 +++++++++++++++++
 rtl/alu_iter.sv | 143 ++++++++++++++
 tb/tb_alu_iter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types for the iterative ALU slice: the op code enum seen on
//   ALUctrlE, the control FSM state type and the is_multicycle() helper
//   that decides which ops go through the iterative datapath.
//
//   Build option: ALU_ITER_DIV_EN. When defined, DIV/DIVU/REM/REMU run on
//   the iterative datapath; otherwise only MUL/MULHU are multi-cycle and
//   the divide op codes are treated as illegal.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULHU = 4'd11,
    ALU_DIV   = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_REM   = 4'd14,
    ALU_REMU  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // Ops that need DATA_WIDTH iterations. The divide ops only qualify when
  // the divider is part of the build; otherwise they complete in one cycle.
  function automatic logic is_multicycle(input alu_op_t op);
`ifdef ALU_ITER_DIV_EN
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIV) ||
           (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
`else
    return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Iterative multiply / divide engine. A start pulse loads the operands,
//   then exactly DATA_WIDTH iterations run (shift-add multiply or restoring
//   divide). done_o is high during the cycle whose clock edge performs the
//   final iteration, and result_o already shows the finished value then, so
//   the parent can capture it on that same edge.
//
//   Ports
//     clk, rst_n  clock and synchronous active-low reset
//     flush       abandon the running operation
//     start_i     load operands and begin iterating
//     op_i        operation (MUL, MULHU and, with the divider, DIV/DIVU/REM/REMU)
//     a_i, b_i    operands
//     done_o      final iteration happens on the coming edge
//     result_o    finished result, valid while done_o is high
//
//   Build option: ALU_ITER_DIV_EN adds the restoring divider and sign fix-up.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  start_i,
  input  alu_op_t               op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LastIter = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] accHi_q, accHi_d;
  logic [DATA_WIDTH-1:0] accLo_q, accLo_d;
  logic [DATA_WIDTH-1:0] operandB_q, operandB_d;
  logic [CNT_W-1:0]      iterCnt_q, iterCnt_d;
  logic                  busy_q, busy_d;
  alu_op_t               opCode_q, opCode_d;

  logic [DATA_WIDTH:0]   mulSum;
  logic [DATA_WIDTH-1:0] stepHi, stepLo;
  logic                  lastStep;

`ifdef ALU_ITER_DIV_EN
  logic                  negQuot_q, negQuot_d;
  logic                  negRem_q, negRem_d;
  logic [DATA_WIDTH:0]   divShifted, divDiff;
  logic                  isDiv;
`endif

  assign lastStep = busy_q && (iterCnt_q == LastIter);
  assign done_o   = lastStep;

  // One iteration of the datapath. Multiply keeps {accHi, accLo} as the
  // partial product with the multiplier shifting out of accLo. Divide keeps
  // the partial remainder in accHi and the dividend/quotient in accLo; the
  // borrow bit of the trial subtraction decides restore vs. keep. Divide by
  // zero falls out naturally as quotient all ones, remainder = dividend.
  always_comb begin
    mulSum = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, operandB_q} : '0);
    stepHi = mulSum[DATA_WIDTH:1];
    stepLo = {mulSum[0], accLo_q[DATA_WIDTH-1:1]};
`ifdef ALU_ITER_DIV_EN
    isDiv      = (opCode_q == ALU_DIV) || (opCode_q == ALU_DIVU) ||
                 (opCode_q == ALU_REM) || (opCode_q == ALU_REMU);
    divShifted = {accHi_q, accLo_q[DATA_WIDTH-1]};
    divDiff    = divShifted - {1'b0, operandB_q};
    if (isDiv) begin
      stepHi = divDiff[DATA_WIDTH] ? divShifted[DATA_WIDTH-1:0] : divDiff[DATA_WIDTH-1:0];
      stepLo = {accLo_q[DATA_WIDTH-2:0], ~divDiff[DATA_WIDTH]};
    end
`endif
  end

  // Final result selection from the values the last iteration produces.
  // Signed divide ran on magnitudes, so the signs are restored here.
  always_comb begin
    result_o = '0;
    case (opCode_q)
      ALU_MUL:   result_o = stepLo;
      ALU_MULHU: result_o = stepHi;
`ifdef ALU_ITER_DIV_EN
      ALU_DIV:   result_o = negQuot_q ? -stepLo : stepLo;
      ALU_DIVU:  result_o = stepLo;
      ALU_REM:   result_o = negRem_q ? -stepHi : stepHi;
      ALU_REMU:  result_o = stepHi;
`endif
      default:   result_o = '0;
    endcase
  end

  // Next-state logic: load on start, iterate while busy, stop after the
  // last iteration. The quotient is only negated for a nonzero divisor so
  // DIV by zero keeps its all-ones answer; most-negative / -1 needs no
  // special case because negating the magnitude 2^(W-1) wraps to itself.
  always_comb begin
    accHi_d    = accHi_q;
    accLo_d    = accLo_q;
    operandB_d = operandB_q;
    iterCnt_d  = iterCnt_q;
    busy_d     = busy_q;
    opCode_d   = opCode_q;
`ifdef ALU_ITER_DIV_EN
    negQuot_d  = negQuot_q;
    negRem_d   = negRem_q;
`endif
    if (start_i) begin
      opCode_d   = op_i;
      accHi_d    = '0;
      accLo_d    = a_i;
      operandB_d = b_i;
      iterCnt_d  = '0;
      busy_d     = 1'b1;
`ifdef ALU_ITER_DIV_EN
      negQuot_d  = 1'b0;
      negRem_d   = 1'b0;
      if ((op_i == ALU_DIV) || (op_i == ALU_REM)) begin
        accLo_d    = a_i[DATA_WIDTH-1] ? -a_i : a_i;
        operandB_d = b_i[DATA_WIDTH-1] ? -b_i : b_i;
        negQuot_d  = (a_i[DATA_WIDTH-1] ^ b_i[DATA_WIDTH-1]) && (b_i != '0);
        negRem_d   = a_i[DATA_WIDTH-1];
      end
`endif
    end else if (busy_q) begin
      accHi_d   = stepHi;
      accLo_d   = stepLo;
      iterCnt_d = iterCnt_q + 1'b1;
      if (lastStep) begin
        busy_d    = 1'b0;
        iterCnt_d = '0;
      end
    end
    if (flush) begin
      busy_d    = 1'b0;
      iterCnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accHi_q    <= '0;
      accLo_q    <= '0;
      operandB_q <= '0;
      iterCnt_q  <= '0;
      busy_q     <= 1'b0;
      opCode_q   <= ALU_ADD;
`ifdef ALU_ITER_DIV_EN
      negQuot_q  <= 1'b0;
      negRem_q   <= 1'b0;
`endif
    end else begin
      accHi_q    <= accHi_d;
      accLo_q    <= accLo_d;
      operandB_q <= operandB_d;
      iterCnt_q  <= iterCnt_d;
      busy_q     <= busy_d;
      opCode_q   <= opCode_d;
`ifdef ALU_ITER_DIV_EN
      negQuot_q  <= negQuot_d;
      negRem_q   <= negRem_d;
`endif
    end
  end

endmodule

// File: rtl/alu_iter.sv
// alu_iter
//   ALU with a valid/ready handshake on both sides. Single-cycle ops finish
//   one cycle after acceptance; MUL/MULHU (and the divide ops when built in)
//   run on alu_muldiv_seq and finish DATA_WIDTH+1 cycles after acceptance.
//   The result is held in DONE until the consumer takes it.
//
//   Ports
//     clk, rst_n          clock and synchronous active-low reset
//     flush               abandon any operation in flight
//     in_valid / in_ready operand handshake (in_ready only in IDLE)
//     SrcAE, SrcBE        operands
//     ALUctrlE            op code (alu_pkg::alu_op_t)
//     out_valid/out_ready result handshake
//     ALUout              result
//     ZeroE               captured SrcAE == captured SrcBE
//
//   Build option: ALU_ITER_DIV_EN enables DIV/DIVU/REM/REMU; without it
//   those op codes complete in one cycle with ALUout = 0.
module alu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  input  alu_op_t               ALUctrlE,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  ZeroE
);

  alu_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;

  logic                  accept;
  logic                  startSeq;
  logic                  seqDone;
  logic [DATA_WIDTH-1:0] seqResult;
  logic [DATA_WIDTH-1:0] aluRes;
  logic [SHAMT_W-1:0]    shamt;

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign startSeq  = accept && is_multicycle(ALUctrlE);
  assign shamt     = SrcBE[SHAMT_W-1:0];
  assign out_valid = (state_q == ST_DONE);
  assign ALUout    = result_q;
  assign ZeroE     = zero_q;

  // Single-cycle results, computed straight from the inputs so they can be
  // registered on the accepting edge. Multi-cycle and illegal op codes fall
  // to the default of zero here.
  always_comb begin
    aluRes = '0;
    case (ALUctrlE)
      ALU_ADD:  aluRes = SrcAE + SrcBE;
      ALU_SUB:  aluRes = SrcAE - SrcBE;
      ALU_AND:  aluRes = SrcAE & SrcBE;
      ALU_OR:   aluRes = SrcAE | SrcBE;
      ALU_XOR:  aluRes = SrcAE ^ SrcBE;
      ALU_SLT:  aluRes = DATA_WIDTH'($signed(SrcAE) < $signed(SrcBE));
      ALU_SLL:  aluRes = SrcAE << shamt;
      ALU_SRL:  aluRes = SrcAE >> shamt;
      ALU_SRA:  aluRes = $unsigned($signed(SrcAE) >>> shamt);
      ALU_SLTU: aluRes = DATA_WIDTH'(SrcAE < SrcBE);
      default:  aluRes = '0;
    endcase
  end

  alu_muldiv_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .start_i  (startSeq),
    .op_i     (ALUctrlE),
    .a_i      (SrcAE),
    .b_i      (SrcBE),
    .done_o   (seqDone),
    .result_o (seqResult)
  );

  // Control FSM. ZeroE is latched at acceptance for every op; the result
  // register loads either the single-cycle value at acceptance or the
  // iterative result on the edge of the final iteration. flush overrides
  // everything, including an acceptance in the same cycle.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          zero_d = (SrcAE == SrcBE);
          if (is_multicycle(ALUctrlE)) begin
            state_d = ST_BUSY;
          end else begin
            state_d  = ST_DONE;
            result_d = aluRes;
          end
        end
      end
      ST_BUSY: begin
        if (seqDone) begin
          state_d  = ST_DONE;
          result_d = seqResult;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter
//   Self-checking bench for alu_iter at DATA_WIDTH=32. Expected values come
//   from a plain-arithmetic reference model (64-bit products, longint
//   division) and from literal values for the directed cases.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcAE;
  logic [W-1:0] SrcBE;
  alu_op_t      ALUctrlE;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUout;
  logic         ZeroE;

  int compared;
  int mismatched;

  alu_iter #(
    .DATA_WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .ALUctrlE  (ALUctrlE),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .ZeroE     (ZeroE)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Time limit so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result straight from the arithmetic definition of each op.
  function automatic logic [W-1:0] refAlu(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    longint         sa;
    longint         sb;
    int unsigned    sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b % W;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLT:   return W'(sa < sb);
      ALU_SLL:   return a << sh;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return W'(sa >>> sh);
      ALU_SLTU:  return W'(a < b);
      ALU_MUL:   return p[W-1:0];
      ALU_MULHU: return p[2*W-1:W];
`ifdef ALU_ITER_DIV_EN
      ALU_DIV:   return (b == 0) ? '1 : W'(sa / sb);
      ALU_DIVU:  return (b == 0) ? '1 : a / b;
      ALU_REM:   return (b == 0) ? a : W'(sa % sb);
      ALU_REMU:  return (b == 0) ? a : a % b;
`endif
      default:   return '0;
    endcase
  endfunction

  // Reference latency in cycles from acceptance to out_valid.
  function automatic int refLat(input alu_op_t op);
    int v;
    v = int'(op);
`ifdef ALU_ITER_DIV_EN
    return (v >= 10) ? W + 1 : 1;
`else
    return (v == 10 || v == 11) ? W + 1 : 1;
`endif
  endfunction

  // Issues one op starting on a negedge, measures latency, optionally keeps
  // out_ready low for 'hold' cycles in DONE while watching the outputs,
  // then takes the result. quietOk reports in_ready low while waiting and
  // stable outputs during the hold; idleOk reports the block back in IDLE.
  task automatic doOp(input alu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                      output logic [W-1:0] res, output logic zero, output int lat,
                      output bit quietOk, output bit idleOk);
    quietOk   = 1'b1;
    ALUctrlE  = op;
    SrcAE     = a;
    SrcBE     = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    SrcAE    = $urandom;
    SrcBE    = $urandom;
    ALUctrlE = alu_op_t'($urandom_range(0, 15));
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) quietOk = 1'b0;
      @(negedge clk);
      lat++;
    end
    res  = ALUout;
    zero = ZeroE;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ALUout !== res || ZeroE !== zero || in_ready !== 1'b0 || out_valid !== 1'b1) quietOk = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    idleOk = (in_ready === 1'b1) && (out_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    SrcAE = '0; SrcBE = '0; ALUctrlE = ALU_ADD;
    repeat (3) @(negedge clk);
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b required 0", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    compared++; if (ALUout !== '0) begin mismatched++; $display("[TB] FAIL reset_aluout: got %h required 0", ALUout); end
    compared++; if (ZeroE !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_zero: got %b required 0", ZeroE); end
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_single_cycle();
    alu_op_t      dOp[5]  = '{ALU_ADD, ALU_SUB, ALU_SRA, ALU_SLT, ALU_SLTU};
    logic [W-1:0] dA[5]   = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] dB[5]   = '{32'd1, 32'd5, 32'h24, 32'd1, 32'd1};
    logic [W-1:0] dExp[5] = '{32'h0, 32'h0, 32'hF8000000, 32'h1, 32'h0};
    logic         dZero[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] res, a, b, expRes;
    logic         zero;
    int           lat;
    bit           q, idle;
    alu_op_t      op;
    for (int i = 0; i < 5; i++) begin
      doOp(dOp[i], dA[i], dB[i], 0, res, zero, lat, q, idle);
      compared++; if (res !== dExp[i]) begin mismatched++; $display("[TB] FAIL directed_res[%0d]: got %h required %h", i, res, dExp[i]); end
      compared++; if (zero !== dZero[i]) begin mismatched++; $display("[TB] FAIL directed_zero[%0d]: got %b required %b", i, zero, dZero[i]); end
      compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL directed_lat[%0d]: got %0d required 1", i, lat); end
    end
    for (int i = 0; i < 40; i++) begin
      op = alu_op_t'($urandom_range(0, 9));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      expRes = refAlu(op, a, b);
      doOp(op, a, b, 0, res, zero, lat, q, idle);
      compared++; if (res !== expRes) begin mismatched++; $display("[TB] FAIL single_res op=%0d a=%h b=%h: got %h required %h", op, a, b, res, expRes); end
      compared++; if (zero !== (a == b)) begin mismatched++; $display("[TB] FAIL single_zero op=%0d: got %b required %b", op, zero, (a == b)); end
      compared++; if (lat !== 1 || !idle) begin mismatched++; $display("[TB] FAIL single_handshake op=%0d: got lat=%0d idle=%0b required lat=1 idle=1", op, lat, idle); end
    end
  endtask

  task automatic test_multiply();
    logic [W-1:0] res, a, b, expRes;
    logic         zero;
    int           lat;
    bit           q, idle;
    alu_op_t      op;
    doOp(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, res, zero, lat, q, idle);
    compared++; if (res !== 32'hFFFFFFFE) begin mismatched++; $display("[TB] FAIL mulhu_res: got %h required fffffffe", res); end
    compared++; if (lat !== 33) begin mismatched++; $display("[TB] FAIL mulhu_lat: got %0d required 33", lat); end
    compared++; if (q !== 1'b1) begin mismatched++; $display("[TB] FAIL mulhu_ready_low: got %b required 1", q); end
    compared++; if (zero !== 1'b1) begin mismatched++; $display("[TB] FAIL mulhu_zero: got %b required 1", zero); end
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? ALU_MUL : ALU_MULHU;
      a  = $urandom;
      b  = $urandom;
      expRes = refAlu(op, a, b);
      doOp(op, a, b, 0, res, zero, lat, q, idle);
      compared++; if (res !== expRes) begin mismatched++; $display("[TB] FAIL mul_res op=%0d a=%h b=%h: got %h required %h", op, a, b, res, expRes); end
      compared++; if (lat !== refLat(op) || !q) begin mismatched++; $display("[TB] FAIL mul_timing op=%0d: got lat=%0d quiet=%0b required lat=%0d quiet=1", op, lat, q, refLat(op)); end
    end
  endtask

  task automatic test_divide();
    alu_op_t      dOp[5] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_DIV};
    logic [W-1:0] dA[5]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd9, 32'd9, 32'h80000000};
    logic [W-1:0] dB[5]  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF};
`ifdef ALU_ITER_DIV_EN
    logic [W-1:0] dExp[5] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'h80000000};
    int           dLat = 33;
`else
    logic [W-1:0] dExp[5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    int           dLat = 1;
`endif
    logic [W-1:0] res, a, b, expRes;
    logic         zero;
    int           lat;
    bit           q, idle;
    alu_op_t      op;
    for (int i = 0; i < 5; i++) begin
      doOp(dOp[i], dA[i], dB[i], 0, res, zero, lat, q, idle);
      compared++; if (res !== dExp[i]) begin mismatched++; $display("[TB] FAIL div_directed_res[%0d]: got %h required %h", i, res, dExp[i]); end
      compared++; if (lat !== dLat) begin mismatched++; $display("[TB] FAIL div_directed_lat[%0d]: got %0d required %0d", i, lat, dLat); end
    end
    for (int i = 0; i < 10; i++) begin
      op = alu_op_t'($urandom_range(12, 15));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = '1;
        2:       b = a;
        3:       b = W'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      expRes = refAlu(op, a, b);
      doOp(op, a, b, 0, res, zero, lat, q, idle);
      compared++; if (res !== expRes) begin mismatched++; $display("[TB] FAIL div_res op=%0d a=%h b=%h: got %h required %h", op, a, b, res, expRes); end
      compared++; if (lat !== refLat(op) || zero !== (a == b)) begin mismatched++; $display("[TB] FAIL div_lat_zero op=%0d: got lat=%0d zero=%b required lat=%0d zero=%b", op, lat, zero, refLat(op), (a == b)); end
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] res;
    logic         zero;
    int           lat;
    bit           q, idle;
    doOp(ALU_OR, 32'h1234_0000, 32'h0000_5678, 5, res, zero, lat, q, idle);
    compared++; if (res !== 32'h12345678) begin mismatched++; $display("[TB] FAIL hold_res: got %h required 12345678", res); end
    compared++; if (q !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_stable: got %b required 1", q); end
    compared++; if (idle !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_release_idle: got %b required 1", idle); end
    doOp(ALU_MUL, 32'd1000, 32'd3000, 5, res, zero, lat, q, idle);
    compared++; if (res !== 32'd3000000 || q !== 1'b1 || idle !== 1'b1) begin mismatched++; $display("[TB] FAIL hold_mul: got res=%h stable=%b idle=%b required res=%h stable=1 idle=1", res, q, idle, 32'd3000000); end
  endtask

  task automatic test_flush();
    logic [W-1:0] res;
    logic         zero;
    int           lat;
    bit           q, idle, sawValid;
    ALUctrlE = ALU_MUL; SrcAE = 32'd77; SrcBE = 32'd99; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_busy: got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready); end
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    compared++; if (sawValid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_late_result: got %b required 0", sawValid); end
    ALUctrlE = ALU_ADD; SrcAE = 32'd7; SrcBE = 32'd8; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_priority: got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready); end
    doOp(ALU_ADD, 32'd2, 32'd3, 0, res, zero, lat, q, idle);
    compared++; if (res !== 32'd5 || lat !== 1) begin mismatched++; $display("[TB] FAIL flush_then_add: got res=%h lat=%0d required res=5 lat=1", res, lat); end
    ALUctrlE = ALU_XOR; SrcAE = 32'hF0; SrcBE = 32'h0F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_done: got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_busy();
    logic [W-1:0] res;
    logic         zero;
    int           lat;
    bit           q, idle, sawValid;
    doOp(ALU_ADD, 32'd1, 32'd1, 0, res, zero, lat, q, idle);
    ALUctrlE = ALU_MULHU; SrcAE = '1; SrcBE = '1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    compared++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_handshake: got ready=%b valid=%b required ready=0 valid=0", in_ready, out_valid); end
    compared++; if (ALUout !== '0 || ZeroE !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_outputs: got aluout=%h zero=%b required aluout=0 zero=0", ALUout, ZeroE); end
    rst_n = 1'b1;
    @(negedge clk);
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_release: got %b required 1", in_ready); end
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    compared++; if (sawValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_no_result: got %b required 0", sawValid); end
    doOp(ALU_MUL, 32'd6, 32'd7, 0, res, zero, lat, q, idle);
    compared++; if (res !== 32'd42 || lat !== 33) begin mismatched++; $display("[TB] FAIL midreset_next_mul: got res=%h lat=%0d required res=2a lat=33", res, lat); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res, a, b, expRes;
    logic         zero;
    int           lat;
    bit           q, idle;
    alu_op_t      op;
    for (int i = 0; i < 20; i++) begin
      op = alu_op_t'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? a : $urandom;
      expRes = refAlu(op, a, b);
      doOp(op, a, b, $urandom_range(0, 2), res, zero, lat, q, idle);
      compared++; if (res !== expRes || zero !== (a == b)) begin mismatched++; $display("[TB] FAIL b2b_res op=%0d a=%h b=%h: got %h/%b required %h/%b", op, a, b, res, zero, expRes, (a == b)); end
      compared++; if (lat !== refLat(op) || !q || !idle) begin mismatched++; $display("[TB] FAIL b2b_timing op=%0d: got lat=%0d quiet=%0b idle=%0b required lat=%0d quiet=1 idle=1", op, lat, q, idle, refLat(op)); end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    @(negedge clk);
    test_reset();
    test_single_cycle();
    test_multiply();
    test_divide();
    test_hold();
    test_flush();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
